// File: rtl/cache_meta_ctrl_if.sv
// CPU request, memory port and metadata RAM port of the cache metadata controller.
// The controller takes the slave view; the surrounding system takes the master view.
interface cache_meta_ctrl_if #(
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned OFF_W  = 3,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wr;
  logic              resp_valid;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wr;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic              meta_en;
  logic              meta_wr;
  logic [IDX_W-1:0]  meta_addr;
  logic              meta_wvalid;
  logic              meta_wdirty;
  logic [TAG_W-1:0]  meta_wtag;
  logic              meta_valid;
  logic              meta_dirty;
  logic [TAG_W-1:0]  meta_tag;

  modport slave (
    input  req_valid, req_addr, req_wr, mem_req_ready, mem_resp_valid,
           meta_valid, meta_dirty, meta_tag,
    output req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wr, mem_req_addr,
           meta_en, meta_wr, meta_addr, meta_wvalid, meta_wdirty, meta_wtag
  );

  modport master (
    output req_valid, req_addr, req_wr, mem_req_ready, mem_resp_valid,
           meta_valid, meta_dirty, meta_tag,
    input  req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wr, mem_req_addr,
           meta_en, meta_wr, meta_addr, meta_wvalid, meta_wdirty, meta_wtag
  );
endinterface

// File: rtl/cache_meta_ctrl.sv
// Direct-mapped cache metadata controller: tag lookup, dirty writeback + refill
// sequencing, and a post-reset invalidation sweep of the (unreset) metadata RAM.
module cache_meta_ctrl #(
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned OFF_W  = 3,
  parameter int unsigned ADDR_W = 32
) (
  input logic              clock,
  input logic              reset,
  cache_meta_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    INIT, IDLE, LOOKUP, WB, WB_WAIT, RF, RF_WAIT, UPDATE, RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_cnt;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             lat_wr;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             unused_off;
  logic             hit;
  logic             accept;

  assign req_tag    = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx    = bus.req_addr[OFF_W +: IDX_W];
  assign unused_off = ^bus.req_addr[OFF_W-1:0];
  assign hit        = bus.meta_valid && (bus.meta_tag == lat_tag);
  assign accept     = bus.req_valid && bus.req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= INIT;
      sweep_cnt         <= '0;
      lat_tag           <= '0;
      lat_idx           <= '0;
      lat_wr            <= 1'b0;
      bus.req_ready     <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_hit      <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_wr    <= 1'b0;
      bus.mem_req_addr  <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + IDX_W'(1);
          if (sweep_cnt == '1) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            lat_tag       <= req_tag;
            lat_idx       <= req_idx;
            lat_wr        <= bus.req_wr;
            bus.req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          // The victim tag is captured straight into the writeback address register.
          if (hit) begin
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b1;
            state          <= RESP;
          end else if (bus.meta_valid && bus.meta_dirty) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_wr    <= 1'b1;
            bus.mem_req_addr  <= {bus.meta_tag, lat_idx, {OFF_W{1'b0}}};
            state             <= WB;
          end else begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_wr    <= 1'b0;
            bus.mem_req_addr  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
            state             <= RF;
          end
        end
        WB: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (bus.mem_resp_valid) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_wr    <= 1'b0;
            bus.mem_req_addr  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
            state             <= RF;
          end
        end
        RF: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= RF_WAIT;
          end
        end
        RF_WAIT: begin
          if (bus.mem_resp_valid) state <= UPDATE;
        end
        UPDATE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_hit   <= 1'b0;
          state          <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_hit   <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  // The RAM port is combinational so the read issues in the accept cycle; reset gates it off.
  always_comb begin
    bus.meta_en     = 1'b0;
    bus.meta_wr     = 1'b0;
    bus.meta_addr   = '0;
    bus.meta_wvalid = 1'b0;
    bus.meta_wdirty = 1'b0;
    bus.meta_wtag   = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          bus.meta_en   = 1'b1;
          bus.meta_wr   = 1'b1;
          bus.meta_addr = sweep_cnt;
        end
        IDLE: begin
          if (accept) begin
            bus.meta_en   = 1'b1;
            bus.meta_addr = req_idx;
          end
        end
        LOOKUP: begin
          if (hit && lat_wr) begin
            bus.meta_en     = 1'b1;
            bus.meta_wr     = 1'b1;
            bus.meta_addr   = lat_idx;
            bus.meta_wvalid = 1'b1;
            bus.meta_wdirty = 1'b1;
            bus.meta_wtag   = lat_tag;
          end
        end
        UPDATE: begin
          bus.meta_en     = 1'b1;
          bus.meta_wr     = 1'b1;
          bus.meta_addr   = lat_idx;
          bus.meta_wvalid = 1'b1;
          bus.meta_wdirty = lat_wr;
          bus.meta_wtag   = lat_tag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_meta_ctrl.md
Name: cache_meta_ctrl

Overview:
- Lookup/update controller that drives one direct-mapped cache tag/valid/dirty metadata RAM. The RAM has 64 sets, a 23-bit tag, and a registered 1-cycle read.
- Accepts CPU line requests and compares tags.
- On a miss, sequences a dirty-victim writeback and then a refill over a valid/ready memory port, and updates the metadata.
- Also sweeps all sets invalid after reset, because the metadata RAM has no reset.

Parameters:
- TAG_W, 23, tag width; must match the metadata RAM.
- IDX_W, 6, set index width (2^IDX_W sets).
- OFF_W, 3, line offset width.
- ADDR_W, 32, address width; must equal TAG_W+IDX_W+OFF_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  request byte address.
- req_wr  in  1  request is a store.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  completed request hit (valid with resp_valid).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wr  out  1  1 = writeback, 0 = refill.
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits 0).
- mem_resp_valid  in  1  one-cycle pulse: memory transaction done.
- meta_en  out  1  metadata RAM enable.
- meta_wr  out  1  metadata RAM write (0 = read).
- meta_addr  out  IDX_W  metadata set index.
- meta_wvalid  out  1  valid bit to write.
- meta_wdirty  out  1  dirty bit to write.
- meta_wtag  out  TAG_W  tag to write.
- meta_valid  in  1  read valid bit; meaningful 1 cycle after a read.
- meta_dirty  in  1  read dirty bit.
- meta_tag  in  TAG_W  read tag.

Behaviour:
- Address split: tag = addr[ADDR_W-1 -: TAG_W], idx = addr[OFF_W +: IDX_W], offset ignored.
- Reset (async): state = INIT, sweep counter = 0, request latches cleared.
  - Outputs on reset: req_ready, resp_valid, resp_hit, mem_req_valid, mem_req_wr, meta_wr and meta_en are 0. mem_req_addr and meta_* data are 0.
- INIT:
  - Each cycle: meta_en=1, meta_wr=1, meta_addr=counter, meta_wvalid=0, meta_wdirty=0, meta_wtag=0; counter increments.
  - After the write with counter=2^IDX_W-1, go to IDLE. The sweep is exactly 64 cycles.
  - req_ready=0 throughout INIT.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr and wr, drive meta_en=1, meta_wr=0, meta_addr=idx, go to LOOKUP.
  - Otherwise meta_en=0.
- LOOKUP:
  - req_ready=0.
  - Capture meta_valid/meta_dirty/meta_tag into victim registers.
  - hit = meta_valid && meta_tag==latched tag.
  - Hit and store: write meta (en=1, wr=1, idx, valid=1, dirty=1, tag) this cycle, then go to RESP with hit=1.
  - Hit and load: go to RESP with hit=1 (no meta write).
  - Miss, victim valid and dirty: go to WB.
  - Miss otherwise: go to RF.
- WB:
  - mem_req_valid=1, mem_req_wr=1, mem_req_addr={victim_tag, idx, 0}.
  - Held stable until mem_req_ready; after the handshake go to WB_WAIT.
- WB_WAIT: on mem_resp_valid go to RF.
- RF:
  - mem_req_valid=1, mem_req_wr=0, mem_req_addr={tag, idx, 0}.
  - Held until the handshake, then go to RF_WAIT.
- RF_WAIT: on mem_resp_valid go to UPDATE.
- UPDATE: meta write with valid=1, dirty=latched wr, tag=latched tag; go to RESP with hit=0.
- RESP: resp_valid=1 and resp_hit driven for exactly one cycle, then go to IDLE.
  - req_ready returns to 1 the following cycle.
- Latency:
  - Hit: handshake at cycle T, resp_valid at T+2.
  - Clean miss: T+2 is the RF cycle. UPDATE occurs 1 cycle after mem_resp_valid, and resp_valid 1 cycle after UPDATE.
- mem_resp_valid outside WB_WAIT/RF_WAIT is ignored.
- mem_req_ready while mem_req_valid=0 is ignored.
- mem_req_valid never deasserts before the handshake, except on reset.
- Only one request is outstanding at a time. There is no back-to-back accept in the RESP cycle.
- meta_en=0 in all states/cycles not listed above.
- Reset mid-operation: all outputs drop immediately (async), in-flight memory transactions are abandoned, and the sweep restarts from set 0.

Test Plan:
- Reset then idle → meta writes to sets 0..63 with valid=0 over 64 consecutive cycles; req_ready=1 on cycle 65.
- Load 0x0000_0108 (idx 33) after init → miss: refill request addr 0x0000_0108, no writeback. After mem_resp_valid, UPDATE writes set 33 (valid=1, dirty=0, tag 0) and RESP has resp_hit=0.
- Repeat load 0x0000_010C → resp_valid at T+2, resp_hit=1, no mem_req_valid.
- Store 0x0000_0108 → hit; meta write set 33 dirty=1 in the LOOKUP cycle; resp_hit=1.
- Load 0x8000_0108 (same idx, tag 0x400000) → writeback request addr 0x0000_0108 (mem_req_wr=1), then refill request addr 0x8000_0108. mem_req_ready held low for 5 cycles; address must stay stable throughout. Final meta: tag 0x400000, dirty=0.
- Assert reset during RF_WAIT → mem_req_valid and resp_valid=0 immediately. A late mem_resp_valid is ignored, and the 64-cycle sweep restarts from set 0.
